// File: rtl/demux16_capture.sv
// demux16_capture: registered 1-to-16 demultiplexer with auto frame fill.
// Auto mode fills lanes 0..15 in order and holds the finished frame until
// frame_ack. Explicit mode writes the lane addressed by sel.
// Optional macro DEMUX16_OVERFLOW_EN adds the sticky 'overflow' output.
//
// state  | meaning
// -------+------------------------------------------------
// S_IDLE | no frame in progress, ptr=0; explicit writes here
// S_FILL | auto capture in progress, ptr = next lane
// S_HOLD | frame complete on Y, frame_valid=1, waiting ack
module demux16_capture #(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    input  logic [3:0]            sel,
    input  logic                  frame_ack,
    output logic [16*WIDTH-1:0]   Y,
    output logic [15:0]           lane_strobe,
    output logic [3:0]            ptr,
    output logic                  frame_valid,
    output logic                  busy
`ifdef DEMUX16_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_ptr;
    logic [3:0]            w_ptr_next;
    logic                  w_we;
    logic [3:0]            w_lane;
    logic [16*WIDTH-1:0]   r_y;
    logic [15:0]           r_strobe;
`ifdef DEMUX16_OVERFLOW_EN
    logic                  w_drop;
    logic                  r_ovf;
`endif

    // State register; clear forces IDLE ahead of any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, write enable, target lane and pointer update.
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_lane       = r_ptr;
        w_ptr_next   = r_ptr;
`ifdef DEMUX16_OVERFLOW_EN
        w_drop       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (din_valid) begin
                    w_we = 1'b1;
                    if (!mode) begin
                        w_lane       = 4'd0;
                        w_ptr_next   = 4'd1;
                        w_next_state = S_FILL;
                    end else begin
                        w_lane = sel;
                    end
                end
            end
            S_FILL: begin
                if (din_valid) begin
                    w_we       = 1'b1;
                    w_lane     = r_ptr;
                    w_ptr_next = r_ptr + 4'd1;
                    if (r_ptr == 4'd15) begin
                        w_next_state = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    // Same-cycle ack and data chains straight into the next frame.
                    if (din_valid) begin
                        w_we         = 1'b1;
                        w_lane       = 4'd0;
                        w_ptr_next   = 4'd1;
                        w_next_state = S_FILL;
                    end else begin
                        w_ptr_next   = 4'd0;
                        w_next_state = S_IDLE;
                    end
                end else begin
`ifdef DEMUX16_OVERFLOW_EN
                    w_drop = din_valid;
`endif
                end
            end
            default: begin
                w_ptr_next   = 4'd0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Lane storage, write strobe and fill pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= 4'd0;
            r_y      <= '0;
            r_strobe <= '0;
        end else if (clear) begin
            r_ptr    <= 4'd0;
            r_y      <= '0;
            r_strobe <= '0;
        end else begin
            r_ptr    <= w_ptr_next;
            r_strobe <= w_we ? (16'h0001 << w_lane) : 16'h0000;
            if (w_we) begin
                r_y[w_lane*WIDTH +: WIDTH] <= din;
            end
        end
    end

`ifdef DEMUX16_OVERFLOW_EN
    // Sticky flag for words dropped while a frame waits for ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign overflow = r_ovf;
`endif

    assign Y           = r_y;
    assign lane_strobe = r_strobe;
    assign ptr         = r_ptr;
    assign frame_valid = (r_state == S_HOLD);
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_demux16_capture.sv
// Scoreboard bench for demux16_capture (WIDTH=4): the stimulus process pushes
// the expected lane write, a monitor pops it whenever a strobe appears.
module tb_demux16_capture;

    localparam int W = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            mode = 1'b0;
    logic [W-1:0]    din = '0;
    logic            din_valid = 1'b0;
    logic [3:0]      sel = 4'd0;
    logic            frame_ack = 1'b0;
    logic [16*W-1:0] Y;
    logic [15:0]     lane_strobe;
    logic [3:0]      ptr;
    logic            frame_valid;
    logic            busy;
`ifdef DEMUX16_OVERFLOW_EN
    logic            overflow;
`endif

    demux16_capture #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .mode        (mode),
        .din         (din),
        .din_valid   (din_valid),
        .sel         (sel),
        .frame_ack   (frame_ack),
        .Y           (Y),
        .lane_strobe (lane_strobe),
        .ptr         (ptr),
        .frame_valid (frame_valid),
        .busy        (busy)
`ifdef DEMUX16_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     strobe;
        logic [16*W-1:0] y;
        logic            fv;
        logic [3:0]      ptr;
    } exp_t;

    exp_t            q[$];
    logic [16*W-1:0] exp_y = '0;
    int              n_pass = 0;
    int              n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_write(input int lane, input logic [W-1:0] d, input logic fv, input logic [3:0] p);
        exp_t e;
        exp_y[lane*W +: W] = d;
        e.strobe = 16'h0001 << lane;
        e.y      = exp_y;
        e.fv     = fv;
        e.ptr    = p;
        q.push_back(e);
    endtask

    // One clock of stimulus; single-cycle controls drop back after the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [3:0] s,
                        input logic m, input logic ack, input logic cl);
        din_valid = v;
        din       = d;
        sel       = s;
        mode      = m;
        frame_ack = ack;
        clear     = cl;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        frame_ack = 1'b0;
        clear     = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (lane_strobe !== 16'h0000) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got %h expected none", lane_strobe);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe", 64'(lane_strobe), 64'(e.strobe));
                chk("lane_data", Y, e.y);
                chk("frame_valid_at_write", 64'(frame_valid), 64'(e.fv));
                chk("ptr_at_write", 64'(ptr), 64'(e.ptr));
            end
        end
    end

    initial begin
        #2;
        chk("reset_Y", Y, 64'h0);
        chk("reset_strobe", 64'(lane_strobe), 64'h0);
        chk("reset_ptr", 64'(ptr), 64'h0);
        chk("reset_fv", 64'(frame_valid), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
`ifdef DEMUX16_OVERFLOW_EN
        chk("reset_ovf", 64'(overflow), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full auto frame, din=k, with one idle cycle mid-frame.
        for (int k = 0; k < 16; k++) begin
            if (k == 8) begin
                step(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0);
                chk("fill_idle_ptr", 64'(ptr), 64'd8);
                chk("fill_idle_busy", 64'(busy), 64'h1);
            end
            push_write(k, W'(k), (k == 15), 4'((k + 1) % 16));
            step(1'b1, W'(k), 4'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("frame1_Y", Y, 64'hFEDCBA9876543210);
        chk("frame1_fv", 64'(frame_valid), 64'h1);
        chk("frame1_ptr", 64'(ptr), 64'h0);

        // Word arriving in HOLD without ack is dropped.
        step(1'b1, 4'h5, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("hold_drop_Y", Y, 64'hFEDCBA9876543210);
        chk("hold_drop_fv", 64'(frame_valid), 64'h1);
`ifdef DEMUX16_OVERFLOW_EN
        chk("hold_drop_ovf", 64'(overflow), 64'h1);
`endif

        // Ack and data together: straight into the next frame.
        push_write(0, 4'hA, 1'b0, 4'd1);
        step(1'b1, 4'hA, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("chain_busy", 64'(busy), 64'h1);
        chk("chain_fv", 64'(frame_valid), 64'h0);
        chk("chain_ptr", 64'(ptr), 64'h1);
        for (int k = 1; k < 16; k++) begin
            push_write(k, W'(15 - k), (k == 15), 4'((k + 1) % 16));
            step(1'b1, W'(15 - k), 4'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("frame2_Y", Y, 64'h0123456789ABCDEA);
        chk("frame2_fv", 64'(frame_valid), 64'h1);

        // Drop again, then clear overriding data and ack.
        step(1'b1, 4'h3, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("frame2_drop_Y", Y, 64'h0123456789ABCDEA);
        step(1'b1, 4'h6, 4'd0, 1'b0, 1'b1, 1'b1);
        exp_y = '0;
        chk("clear_Y", Y, 64'h0);
        chk("clear_fv", 64'(frame_valid), 64'h0);
        chk("clear_busy", 64'(busy), 64'h0);
        chk("clear_ptr", 64'(ptr), 64'h0);
        chk("clear_strobe", 64'(lane_strobe), 64'h0);
`ifdef DEMUX16_OVERFLOW_EN
        chk("clear_ovf", 64'(overflow), 64'h0);
`endif

        // Ack with no frame pending does nothing.
        step(1'b0, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("stray_ack_busy", 64'(busy), 64'h0);
        chk("stray_ack_fv", 64'(frame_valid), 64'h0);

        // Explicit mode writes.
        push_write(9, 4'h1, 1'b0, 4'd0);
        step(1'b1, 4'h1, 4'd9, 1'b1, 1'b0, 1'b0);
        push_write(3, 4'h1, 1'b0, 4'd0);
        step(1'b1, 4'h1, 4'd3, 1'b1, 1'b0, 1'b0);
        chk("explicit_Y", Y, 64'h0000_0010_0000_1000);
        chk("explicit_busy", 64'(busy), 64'h0);
        chk("explicit_fv", 64'(frame_valid), 64'h0);

        // Reset after 7 auto words.
        for (int k = 0; k < 7; k++) begin
            push_write(k, W'(k + 1), 1'b0, 4'(k + 1));
            step(1'b1, W'(k + 1), 4'd0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_y = '0;
        chk("midrst_Y", Y, 64'h0);
        chk("midrst_ptr", 64'(ptr), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_strobe", 64'(lane_strobe), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_write(0, 4'h7, 1'b0, 4'd1);
        step(1'b1, 4'h7, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_busy", 64'(busy), 64'h1);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
